// File: rtl/gnrl_ram_2p_pkg.sv
// Shared constants and state type for the two-port general RAM.
package gnrl_ram_2p_pkg;

  localparam logic WriteEnable = 1'b1;
  localparam logic RstEnable   = 1'b0;

  // CLEAR zeroes the array word by word; RUN opens both channels.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_e;

endpackage

// File: rtl/gnrl_ram_2p_byte_merge.sv
// Byte-granular merge: bytes selected by mask come from new_data, the rest from old_data.
module gnrl_byte_merge
  import gnrl_ram_2p_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] mask,
  output logic [DATA_WIDTH-1:0]   merged
);

  logic [DATA_WIDTH-1:0] bit_mask;

  // Expand each byte-enable bit across its eight data bits.
  always_comb begin
    bit_mask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
      bit_mask[8*i +: 8] = {8{mask[i]}};
    end
  end

  assign merged = (old_data & ~bit_mask) | (new_data & bit_mask);

endmodule

// File: rtl/gnrl_ram_2p.sv
// Two-port (one write, one read) synchronous RAM with valid/ready channels,
// a registered back-pressurable read response and an optional post-reset clear.
module gnrl_ram_2p
  import gnrl_ram_2p_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter bit          INIT_MEM     = 1'b0,
  parameter              INIT_FILE    = "",
  parameter bit          CLEAR_ON_RST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH/8-1:0] wr_mask_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_req_valid_i,
  output logic                    rd_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic                    rd_rsp_valid_o,
  input  logic                    rd_rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rd_rsp_data_o,
  output logic                    init_done_o
);

  localparam int unsigned BYTES   = DATA_WIDTH / 8;
  localparam int unsigned OFFSET  = $clog2(BYTES);
  localparam int unsigned WADDR_W = ADDR_WIDTH - OFFSET;
  localparam int unsigned DEPTH   = 2 ** WADDR_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ram_state_e            state_q, state_d;
  logic [WADDR_W-1:0]    clr_cnt_q;
  logic                  live_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic [WADDR_W-1:0]    waddr, raddr;
  logic                  run;
  logic                  wr_we, rd_fire, clr_we, collide;
  logic [DATA_WIDTH-1:0] wr_old, rd_old, wr_merged, rd_fwd, rd_word;

  // Sub-word address bits select a byte lane only; the array is word-addressed.
  if (OFFSET > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^{wr_addr_i[OFFSET-1:0], rd_addr_i[OFFSET-1:0]};
  end

  assign waddr = wr_addr_i[ADDR_WIDTH-1:OFFSET];
  assign raddr = rd_addr_i[ADDR_WIDTH-1:OFFSET];

  // live_q keeps the channels shut during reset even when reset lands directly in RUN.
  assign run            = live_q && (state_q == RUN);
  assign init_done_o    = run;
  assign wr_ready_o     = run;
  assign rd_req_ready_o = run && (!rsp_valid_q || rd_rsp_ready_i);
  assign rd_rsp_valid_o = rsp_valid_q;
  assign rd_rsp_data_o  = rsp_data_q;

  assign wr_we   = wr_valid_i && wr_ready_o;
  assign rd_fire = rd_req_valid_i && rd_req_ready_o;
  assign clr_we  = (rst != RstEnable) && (state_q == CLEAR);
  assign collide = (wr_we == WriteEnable) && rd_fire && (waddr == raddr);

  assign wr_old = mem[waddr];
  assign rd_old = mem[raddr];

  gnrl_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_wr_merge (
    .old_data (wr_old),
    .new_data (wr_data_i),
    .mask     (wr_mask_i),
    .merged   (wr_merged)
  );

  gnrl_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_rd_fwd (
    .old_data (rd_old),
    .new_data (wr_data_i),
    .mask     (wr_mask_i),
    .merged   (rd_fwd)
  );

  // Same-word write and read in one cycle return the write-merged word.
  assign rd_word = collide ? rd_fwd : rd_old;

  // Next-state: CLEAR runs until the last word has been zeroed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (clr_cnt_q == '1) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register, clear counter and reset-release flag.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= CLEAR_ON_RST ? CLEAR : RUN;
      clr_cnt_q <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  // Read response register: load on accept, drop valid on consume, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rd_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= rd_word;
    end else if (rsp_valid_q && rd_rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Array write port: clear sequence or masked write; contents survive reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_we == WriteEnable) begin
      mem[waddr] <= wr_merged;
    end
  end

endmodule

// File: doc/gnrl_ram_2p.md
# gnrl_ram_2p

Parametrised two-port (one write, one read) synchronous RAM that succeeds the single-port combinational-read general RAM. Write and read channels each use a valid/ready handshake. Reads have a registered, back-pressurable response. The byte mask scales with `DATA_WIDTH`, and an optional post-reset clear sequence zeroes the array. It sits behind the core's instruction/data memory interfaces, where separate fetch and load/store traffic needs concurrent access.

## Interface
- `ADDR_WIDTH`, 16: byte-address width.
- `DATA_WIDTH`, 32: word width; must be a multiple of 8 and a power of two ≥ 8.
- `INIT_MEM`, 0: 1 → `$readmemh(INIT_FILE)` at time 0.
- `INIT_FILE`, "": hex image path.
- `CLEAR_ON_RST`, 0: 1 → zero the whole array after every reset.
- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-low (`RstEnable` = 0).
- `wr_valid_i` input 1: write request.
- `wr_ready_o` output 1: write accepted when high together with `wr_valid_i`.
- `wr_addr_i` input `ADDR_WIDTH`: write byte address.
- `wr_mask_i` input `DATA_WIDTH/8`: byte enables; bit i covers `data[8i+7:8i]`.
- `wr_data_i` input `DATA_WIDTH`: write data.
- `rd_req_valid_i` input 1: read request.
- `rd_req_ready_o` output 1: read request accepted.
- `rd_addr_i` input `ADDR_WIDTH`: read byte address.
- `rd_rsp_valid_o` output 1: read data valid.
- `rd_rsp_ready_i` input 1: consumer takes the response.
- `rd_rsp_data_o` output `DATA_WIDTH`: read data.
- `init_done_o` output 1: array usable; channels are open.

## Operation
- `BYTES = DATA_WIDTH/8`, `OFFSET = log2(BYTES)`, `DEPTH = 2^(ADDR_WIDTH-OFFSET)`.
- Word address is `addr[ADDR_WIDTH-1:OFFSET]`. The low `OFFSET` bits are ignored.
- FSM has two states, `CLEAR` and `RUN`.
  - Reset enters `CLEAR` when `CLEAR_ON_RST=1`, otherwise `RUN`.
  - In `CLEAR`, a counter `clr_cnt` (reset 0) writes all-zero to `mem[clr_cnt]` each cycle and increments.
  - After the write to word `DEPTH-1`, the FSM goes to `RUN`.
  - No `CLEAR` exit from `RUN` except via reset.
- In `CLEAR`, `wr_ready_o`, `rd_req_ready_o` and `init_done_o` are all 0.
- In `RUN`, `init_done_o` is 1.
- Write channel:
  - `wr_ready_o` = 1 in `RUN`.
  - On a handshake, byte i of `mem[waddr]` takes `wr_data_i` byte i where `wr_mask_i[i]`=1; other bytes keep their value.
  - A handshake with an all-zero mask is accepted and changes nothing.
- Read channel:
  - `rd_req_ready_o` = `RUN && (!rd_rsp_valid_o || rd_rsp_ready_i)`.
  - On a handshake, the response register loads `mem[raddr]` and `rd_rsp_valid_o` is set.
  - When `rd_rsp_valid_o && rd_rsp_ready_i` with no new request, valid clears and the data register holds its old value.
  - While the response is stalled (valid=1, ready=0), data and valid are held stable.
- Collision: a write and a read handshake in the same cycle to the same word is write-first. The response equals the old word with the masked new bytes merged in. Different words are independent.
- Reset mid-operation (any state or `clr_cnt`):
  - FSM, `clr_cnt` and the response register return to their reset values.
  - A pending response is dropped.
  - Array contents are untouched except by the new clear sequence.

## Timing
- Reset values: `wr_ready_o`=0, `rd_req_ready_o`=0, `rd_rsp_valid_o`=0, `rd_rsp_data_o`=0, `init_done_o`=0. All are held while `rst`=0.
- With `CLEAR_ON_RST=0`, `wr_ready_o`, `rd_req_ready_o` and `init_done_o` rise in the first cycle with `rst`=1.
- With `CLEAR_ON_RST=1`, these rise `DEPTH` cycles after the first cycle with `rst`=1.
- Write latency: a write accepted at edge N is visible to a read accepted at edge N+1. Same-edge visibility is covered by the collision rule.
- Read latency is 1: a request accepted at edge N has its response valid from edge N through the edge at which it is consumed.
- Sustained throughput is one read plus one write per cycle when `rd_rsp_ready_i`=1.
- `rd_req_ready_o` depends combinationally on `rd_rsp_ready_i`. No other combinational input-to-output paths exist.

## Structure
- Shared package/defines holds `WriteEnable`, `RstEnable`, and the `CLEAR`/`RUN` state encoding as `localparam` constants.
- One sub-module, `gnrl_byte_merge`, is parametrised by `DATA_WIDTH`.
  - Function: `out = (old & ~expand(mask)) | (new & expand(mask))`.
  - It is used for both the array write and collision forwarding.
- The array is a plain `reg` array, so tools infer block RAM.
- The `clr_cnt` width is `ADDR_WIDTH-OFFSET`; the counter needs no wrap logic because the FSM leaves `CLEAR` at `DEPTH-1`.

## Test plan
- Clear sequence: `ADDR_WIDTH`=6, `DATA_WIDTH`=32, `CLEAR_ON_RST`=1, array preloaded with `0xFFFFFFFF`; release reset → `init_done_o` rises after exactly 16 cycles, and reads of words 0–15 return 0.
- Byte-mask write: write `0xAABBCCDD` with mask `0xF` to `0x10`, then `0x11223344` with mask `0x5` to `0x10`; read `0x10` → `0xAA22CC44` one cycle after acceptance.
- Collision: word 4 holds `0x01020304`; same-cycle write `0xFFFFFFFF` with mask `0x8` and read of `0x10` → response `0xFF020304`.
- Backpressure: issue reads of words 0, 1, 2 with `rd_rsp_ready_i`=0 for 3 cycles → `rd_req_ready_o`=0 after the first accept, word 0 data is held stable, and no request is lost once ready returns.
- Mid-clear reset: assert `rst`=0 at `clr_cnt`=7, release → the clear restarts from word 0 and `init_done_o` rises 16 cycles later.
- Wide config: `DATA_WIDTH`=64, mask `0x81` write to byte address `0x08` → only bytes 0 and 7 of word 1 change, and the low 3 address bits are ignored.
